// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared fetch-stage types, exception codes and address helpers
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    localparam logic [4:0]  EXC_ADEL  = 5'd4;
    localparam logic [4:0]  EXC_IBE   = 5'd6;
    localparam logic [31:0] KSEG_MASK = 32'h1FFFFFFF;

    // kseg0 (100) and kseg1 (101) both map straight onto low physical memory
    function automatic logic is_kseg01(input logic [31:0] vaddr);
        return vaddr[31:30] == 2'b10;
    endfunction

endpackage

// File: rtl/vaddr_xlate.sv
// rtl/vaddr_xlate.sv - combinational fixed-mapping virtual to physical translation
module vaddr_xlate
    import inst_fetch_pkg::*;
(
    input  logic [31:0] vaddr,
    output logic [31:0] paddr
);

    assign paddr = is_kseg01(vaddr) ? (vaddr & KSEG_MASK) : vaddr;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: req/ack bus read into a registered ir/ir_pc pair
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned  TIMEOUT_CYCLES = 255,
    parameter logic [31:0]  NOP_WORD       = 32'h00000000
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [31:0] pc_addr,
    input  logic        flush,
    input  logic        id_ready,
    output logic        pc_hold,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    output logic        ir_exc,
    output logic [4:0]  ir_exc_code
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    fetch_state_t state, state_d;
    logic [7:0]   cnt, cnt_d;
    logic [31:0]  phys;
    logic [31:0]  ir_d, ir_pc_d, ibus_addr_d;
    logic         ir_valid_d, ir_exc_d, ibus_req_d;
    logic [4:0]   ir_exc_code_d;
    logic         load;
    logic         slot_free;
    logic         timeout;

    vaddr_xlate u_xlate (
        .vaddr (pc_addr),
        .paddr (phys)
    );

    assign slot_free = !ir_valid || id_ready;
    assign timeout   = (cnt == TO_LAST);
    assign pc_hold   = !(flush || load);

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        ir_d          = ir;
        ir_pc_d       = ir_pc;
        ir_valid_d    = ir_valid && !id_ready;
        ir_exc_d      = ir_exc;
        ir_exc_code_d = ir_exc_code;
        ibus_req_d    = ibus_req;
        ibus_addr_d   = ibus_addr;
        load          = 1'b0;

        case (state)
            S_IDLE: begin
                if (flush) begin
                    ir_valid_d = 1'b0;
                end else if (slot_free && (pc_addr[1:0] != 2'b00)) begin
                    load          = 1'b1;
                    ir_d          = NOP_WORD;
                    ir_pc_d       = pc_addr;
                    ir_valid_d    = 1'b1;
                    ir_exc_d      = 1'b1;
                    ir_exc_code_d = EXC_ADEL;
                end else if (slot_free) begin
                    ir_pc_d     = pc_addr;
                    ibus_addr_d = phys;
                    ibus_req_d  = 1'b1;
                    cnt_d       = 8'd0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    ir_valid_d = 1'b0;
                    // the bus cycle must complete; S_DROP swallows its result
                    if (ibus_ack || timeout) begin
                        ibus_req_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        cnt_d   = cnt + 8'd1;
                        state_d = S_DROP;
                    end
                end else if (ibus_ack) begin
                    load          = 1'b1;
                    ir_d          = ibus_rdata;
                    ir_valid_d    = 1'b1;
                    ir_exc_d      = 1'b0;
                    ir_exc_code_d = 5'd0;
                    ibus_req_d    = 1'b0;
                    state_d       = S_IDLE;
                end else if (timeout) begin
                    load          = 1'b1;
                    ir_d          = NOP_WORD;
                    ir_valid_d    = 1'b1;
                    ir_exc_d      = 1'b1;
                    ir_exc_code_d = EXC_IBE;
                    ibus_req_d    = 1'b0;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            S_DROP: begin
                if (flush) begin
                    ir_valid_d = 1'b0;
                end
                if (ibus_ack || timeout) begin
                    ibus_req_d = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            default: begin
                ibus_req_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            ir          <= NOP_WORD;
            ir_pc       <= 32'd0;
            ir_valid    <= 1'b0;
            ir_exc      <= 1'b0;
            ir_exc_code <= 5'd0;
            ibus_req    <= 1'b0;
            ibus_addr   <= 32'd0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            ir          <= ir_d;
            ir_pc       <= ir_pc_d;
            ir_valid    <= ir_valid_d;
            ir_exc      <= ir_exc_d;
            ir_exc_code <= ir_exc_code_d;
            ibus_req    <= ibus_req_d;
            ibus_addr   <= ibus_addr_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
module tb_inst_fetch;

    localparam int TO = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] paddr;
        logic [31:0] rdata;
        int          ack_after;
    } vec_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        exc;
        logic [4:0]  code;
    } exp_t;

    logic        clk = 1'b0;
    logic        rest;
    logic [31:0] pc_addr;
    logic        flush;
    logic        id_ready;
    logic        pc_hold;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack;
    logic [31:0] ibus_rdata;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_exc;
    logic [4:0]  ir_exc_code;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    vec_t vt[9];

    inst_fetch #(.TIMEOUT_CYCLES(TO), .NOP_WORD(32'h00000000)) dut (
        .clk         (clk),
        .rest        (rest),
        .pc_addr     (pc_addr),
        .flush       (flush),
        .id_ready    (id_ready),
        .pc_hold     (pc_hold),
        .ibus_req    (ibus_req),
        .ibus_addr   (ibus_addr),
        .ibus_ack    (ibus_ack),
        .ibus_rdata  (ibus_rdata),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_exc      (ir_exc),
        .ir_exc_code (ir_exc_code)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, "_valid"}, ir_valid, 1);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_sb: got 0 queued entries, expected 1", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_ir"}, ir, e.ir);
            chk({tag, "_ir_pc"}, ir_pc, e.pc);
            chk({tag, "_exc"}, ir_exc, e.exc);
            if (e.exc) chk({tag, "_code"}, ir_exc_code, e.code);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the load.
    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        int   age;
        bit   done;
        pc_addr  = v.pc;
        ibus_ack = 1'b0;
        if (v.pc[1:0] != 2'b00)  e = '{32'h0, v.pc, 1'b1, 5'd4};
        else if (v.ack_after < 0) e = '{32'h0, v.pc, 1'b1, 5'd6};
        else                      e = '{v.rdata, v.pc, 1'b0, 5'd0};
        sb.push_back(e);
        #1;
        chk({tag, "_req_idle"}, ibus_req, 0);
        if (v.pc[1:0] != 2'b00) begin
            chk({tag, "_hold_adel"}, pc_hold, 0);
        end else begin
            chk({tag, "_hold_issue"}, pc_hold, 1);
            age  = 0;
            done = 0;
            while (!done && age < 20) begin
                @(negedge clk);
                chk({tag, "_req"}, ibus_req, 1);
                chk({tag, "_addr"}, ibus_addr, v.paddr);
                if (age == v.ack_after) begin
                    ibus_ack   = 1'b1;
                    ibus_rdata = v.rdata;
                    done       = 1;
                end else if (v.ack_after < 0 && age == TO - 1) begin
                    done = 1;
                end
                #1;
                chk({tag, "_hold"}, pc_hold, done ? 0 : 1);
                age++;
            end
            if (!done) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s_bound: got no ack/timeout, expected completion", tag);
            end
        end
        @(negedge clk);
        ibus_ack   = 1'b0;
        ibus_rdata = 32'hDEADBEEF;
        pop_check(tag);
        chk({tag, "_req_drop"}, ibus_req, 0);
    endtask

    initial begin
        vec_t v;
        vt[0] = '{32'h9fc00000, 32'h1fc00000, 32'h3c1d0000, 0};
        vt[1] = '{32'h9fc00004, 32'h1fc00004, 32'h27bd0100, 2};
        vt[2] = '{32'h9fc00002, 32'h00000000, 32'h00000000, 0};
        vt[3] = '{32'hbfc00008, 32'h1fc00008, 32'h8c880000, 1};
        vt[4] = '{32'h00400000, 32'h00400000, 32'h0c100040, 0};
        vt[5] = '{32'hc0001000, 32'hc0001000, 32'h03e00008, 3};
        vt[6] = '{32'h80000010, 32'h00000010, 32'h00000000, -1};
        vt[7] = '{32'h00400003, 32'h00000000, 32'h00000000, 0};
        vt[8] = '{32'h7ffffffc, 32'h7ffffffc, 32'hffffffff, 0};

        rest       = 1'b1;
        flush      = 1'b0;
        id_ready   = 1'b1;
        ibus_ack   = 1'b0;
        ibus_rdata = 32'h0;
        pc_addr    = 32'h9fc00000;
        repeat (2) @(negedge clk);
        chk("rst_ir", ir, 32'h0);
        chk("rst_ir_pc", ir_pc, 32'h0);
        chk("rst_valid", ir_valid, 0);
        chk("rst_exc", ir_exc, 0);
        chk("rst_code", ir_exc_code, 0);
        chk("rst_req", ibus_req, 0);
        chk("rst_addr", ibus_addr, 32'h0);
        rest = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // flush one cycle into the wait, ack arrives while dropping
        pc_addr = 32'h9fc00020;
        #1 chk("fl_hold_issue", pc_hold, 1);
        @(negedge clk);
        chk("fl_req_wait", ibus_req, 1);
        flush = 1'b1;
        #1 chk("fl_hold_flush", pc_hold, 0);
        @(negedge clk);
        flush   = 1'b0;
        pc_addr = 32'h9fc00040;
        chk("fl_req_drop1", ibus_req, 1);
        chk("fl_addr_drop1", ibus_addr, 32'h1fc00020);
        chk("fl_valid_drop1", ir_valid, 0);
        #1 chk("fl_hold_drop1", pc_hold, 1);
        @(negedge clk);
        chk("fl_req_drop2", ibus_req, 1);
        ibus_ack   = 1'b1;
        ibus_rdata = 32'h12345678;
        #1 chk("fl_hold_drop2", pc_hold, 1);
        @(negedge clk);
        ibus_ack = 1'b0;
        chk("fl_req_done", ibus_req, 0);
        chk("fl_valid_done", ir_valid, 0);
        v = '{32'h9fc00040, 32'h1fc00040, 32'h24080007, 0};
        run_vec(v, "redir");

        // flush and ack in the same cycle
        pc_addr = 32'h9fc00060;
        @(negedge clk);
        flush      = 1'b1;
        ibus_ack   = 1'b1;
        ibus_rdata = 32'hAAAA5555;
        #1 chk("fa_hold", pc_hold, 0);
        @(negedge clk);
        flush    = 1'b0;
        ibus_ack = 1'b0;
        chk("fa_req", ibus_req, 0);
        chk("fa_valid", ir_valid, 0);
        pc_addr = 32'h9fc00100;

        // decode stall: no issue while the slot is full, issue as soon as it frees
        sb.push_back('{32'h24020001, 32'h9fc00100, 1'b0, 5'd0});
        #1 chk("st_hold_issue", pc_hold, 1);
        @(negedge clk);
        id_ready = 1'b0;
        chk("st_req", ibus_req, 1);
        ibus_ack   = 1'b1;
        ibus_rdata = 32'h24020001;
        #1 chk("st_hold_ack", pc_hold, 0);
        @(negedge clk);
        ibus_ack = 1'b0;
        pop_check("st_load");
        pc_addr = 32'h9fc00104;
        #1 chk("st_hold_full", pc_hold, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("st_req_stall", ibus_req, 0);
            chk("st_ir_stall", ir, 32'h24020001);
            chk("st_pc_stall", ir_pc, 32'h9fc00100);
            chk("st_valid_stall", ir_valid, 1);
            chk("st_hold_stall", pc_hold, 1);
        end
        id_ready = 1'b1;
        #1 chk("st_hold_release", pc_hold, 1);
        @(negedge clk);
        chk("st_req_release", ibus_req, 1);
        chk("st_addr_release", ibus_addr, 32'h1fc00104);
        chk("st_valid_release", ir_valid, 0);
        sb.push_back('{32'h00851020, 32'h9fc00104, 1'b0, 5'd0});
        ibus_ack   = 1'b1;
        ibus_rdata = 32'h00851020;
        #1 chk("st_hold_ack2", pc_hold, 0);
        @(negedge clk);
        ibus_ack = 1'b0;
        pop_check("st_load2");

        // asynchronous reset in the middle of a wait, then a stale ack
        pc_addr = 32'h9fc00200;
        @(negedge clk);
        chk("ar_req_pre", ibus_req, 1);
        #2 rest = 1'b1;
        #1;
        chk("ar_req", ibus_req, 0);
        chk("ar_addr", ibus_addr, 32'h0);
        chk("ar_valid", ir_valid, 0);
        chk("ar_ir", ir, 32'h0);
        chk("ar_ir_pc", ir_pc, 32'h0);
        chk("ar_exc", ir_exc, 0);
        chk("ar_code", ir_exc_code, 0);
        @(negedge clk);
        rest       = 1'b0;
        ibus_ack   = 1'b1;
        ibus_rdata = 32'hBADBAD00;
        #1 chk("ar_hold_stale", pc_hold, 1);
        @(negedge clk);
        ibus_ack = 1'b0;
        chk("ar_req_reissue", ibus_req, 1);
        chk("ar_valid_stale", ir_valid, 0);
        sb.push_back('{32'h3c080000, 32'h9fc00200, 1'b0, 5'd0});
        ibus_ack   = 1'b1;
        ibus_rdata = 32'h3c080000;
        #1 chk("ar_hold_ack", pc_hold, 0);
        @(negedge clk);
        ibus_ack = 1'b0;
        pop_check("ar_load");

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
